// File: rtl/contador_salida.sv
// contador_salida: output-side pop monitor for the QoS interconnect.
// Keeps saturating word counters per destination (D0, D1) and per traffic
// class (VC0, VC1), and returns one selected counter through a req/valid
// handshake that is only honoured while the interconnect is idle.
module contador_salida #(
    parameter int unsigned BW = 6,
    parameter int unsigned CW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          D0_rd,
    input  logic          D0_empty,
    input  logic [BW-1:0] D0_data_out,
    input  logic          D1_rd,
    input  logic          D1_empty,
    input  logic [BW-1:0] D1_data_out,
    input  logic          idle_in,
    input  logic          req,
    input  logic [1:0]    idx,
    input  logic          clear,
    output logic          valid,
    output logic [CW-1:0] data,
    output logic          sat_flag
);

    localparam logic [CW:0] MaxVal = {1'b0, {CW{1'b1}}};

    typedef enum logic {
        StWait,
        StResp
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] snap_q, snap_d;
    logic [CW-1:0] cnt_q [4];
    logic [CW-1:0] cnt_d [4];
    logic          sat_q, sat_d;

    logic          pop0, pop1;
    logic          cls0, cls1;
    logic [1:0]    inc [4];
    logic [CW:0]   sum [4];
    logic          sat_hit;

    // Only the class bit of the read data matters; the payload bits are
    // consumed here so they do not show up as dangling inputs.
    logic unused_payload;
    assign unused_payload = ^{D0_data_out[BW-2:0], D1_data_out[BW-2:0]};

    // Effective pops and per-counter increments (class counters can take 2).
    always_comb begin
        pop0   = D0_rd & ~D0_empty;
        pop1   = D1_rd & ~D1_empty;
        cls0   = D0_data_out[BW-1];
        cls1   = D1_data_out[BW-1];
        inc[0] = {1'b0, pop0};
        inc[1] = {1'b0, pop1};
        inc[2] = {1'b0, pop0 & ~cls0} + {1'b0, pop1 & ~cls1};
        inc[3] = {1'b0, pop0 & cls0} + {1'b0, pop1 & cls1};
    end

    // Saturating counter update; clear wins over any pop in the same cycle.
    always_comb begin
        sat_hit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sum[k] = {1'b0, cnt_q[k]} + {{(CW - 1){1'b0}}, inc[k]};
            if (sum[k] > MaxVal) begin
                cnt_d[k] = MaxVal[CW-1:0];
                sat_hit  = 1'b1;
            end else begin
                cnt_d[k] = sum[k][CW-1:0];
            end
        end
        sat_d = sat_q | sat_hit;
        if (clear) begin
            for (int k = 0; k < 4; k++) begin
                cnt_d[k] = '0;
            end
            sat_d = 1'b0;
        end
    end

    // Read handshake: accept in WAIT when idle, answer for one cycle in RESP.
    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        unique case (state_q)
            StWait: begin
                if (req && idle_in) begin
                    snap_d  = cnt_q[idx];
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StWait;
            end
            default: begin
                state_d = StWait;
            end
        endcase
    end

    // Outputs decode straight from registered state.
    always_comb begin
        valid    = (state_q == StResp);
        data     = snap_q;
        sat_flag = sat_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StWait;
            snap_q  <= '0;
            sat_q   <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            sat_q   <= sat_d;
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

endmodule

// File: doc/contador_salida.md
Name: contador_salida

Overview:
- Downstream consumer stage of the QoS interconnect. It monitors pops from the D0/D1 output FIFOs and keeps four saturating word counters: per destination and per traffic class.
- A request/valid handshake exposes one selected counter to the bench or host. Requests are accepted only while the interconnect FSM reports idle, so counts are read only after traffic has drained.

Parameters:
- BW, 6, data word width; bit BW-1 is the class bit (0 = VC0, 1 = VC1).
- CW, 5, counter width; counters saturate at 2^CW-1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- D0_rd  input  1  pop strobe to FIFO D0.
- D0_empty  input  1  D0 empty flag.
- D0_data_out  input  BW  D0 read data, valid in the pop cycle.
- D1_rd  input  1  pop strobe to FIFO D1.
- D1_empty  input  1  D1 empty flag.
- D1_data_out  input  BW  D1 read data, valid in the pop cycle.
- idle_in  input  1  interconnect FSM idle indication (idle_out_cond).
- req  input  1  read request.
- idx  input  2  counter select: 0=D0, 1=D1, 2=class0, 3=class1.
- clear  input  1  synchronous clear of all counters and sat_flag.
- valid  output  1  one-cycle pulse; data is meaningful when high.
- data  output  CW  selected counter snapshot.
- sat_flag  output  1  sticky; set when any counter saturates.

Behaviour:
- Reset: all counters 0, state WAIT, valid=0, data=0, sat_flag=0. While reset=1, every other input is ignored.
- Effective pop: pop0 = D0_rd & ~D0_empty; pop1 = D1_rd & ~D1_empty. A strobe on an empty FIFO does not count.
- cnt[0] += pop0.
- cnt[1] += pop1.
- cnt[2] += (pop0 & ~D0_data_out[BW-1]) + (pop1 & ~D1_data_out[BW-1]).
- cnt[3] += (pop0 & D0_data_out[BW-1]) + (pop1 & D1_data_out[BW-1]).
- Class counters can increment by 2 in one cycle (simultaneous same-class pops).
- Arithmetic: compute in CW+1 bits, then clamp to 2^CW-1. sat_flag is set on any clamp, or on any increment attempted at the maximum value. A counter at its maximum stays there.
- clear has priority over pops: in a clear cycle all counters become 0 and those cycles' pops are lost. sat_flag is cleared.
- FSM states:
  - WAIT: if req & idle_in, latch snap <= cnt[idx] (value before this cycle's pops/clear), go to RESP. If req & ~idle_in, the request is dropped (no response); stay in WAIT.
  - RESP: valid=1, data=snap for exactly one cycle; unconditionally return to WAIT. A req in RESP is ignored. Back-to-back requests therefore yield at most one valid every 2 cycles.
- Latency: req accepted at edge N -> valid high in the cycle after edge N, falls at edge N+1.
- data holds the last snapshot after valid falls; it changes only on acceptance.
- Counting continues in all states, including RESP.
- Reset asserted in RESP: valid=0 and data=0 at the next edge.
- idx is sampled only at acceptance.

Test Plan:
- Reset, then 3 D0 pops with data 6'b00_0101, 6'b01_0111, 6'b10_1000 and idle_in=1; req idx=0 -> one-cycle valid, data=3. Then req idx=3 -> data=1. Then req idx=2 -> data=2.
- D0_rd=1 with D0_empty=1 for 4 cycles; req idx=0 -> data=0.
- Same cycle pop0 data 6'b10_0110 and pop1 data 6'b11_0000; req idx=3 -> data=2. Then req idx=1 -> data=1.
- 33 D1 pops with CW=5 -> req idx=1 returns 31 and sat_flag=1. Then clear -> sat_flag=0 and req idx=1 returns 0.
- req with idle_in=0 -> no valid for 5 cycles. Then req held high 4 cycles with idle_in=1 -> exactly 2 valid pulses, spaced 2 cycles apart.
- req accepted, then reset=1 in the RESP cycle -> valid=0 and data=0 after the edge, and all counters read back 0 afterwards.
